// File: rtl/cache_types_pkg.sv
// Shared cache/bmem types: responder FSM states and bmem beat/line geometry.
package cache_types;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_LAT,
        RD_BURST
    } bmem_resp_state_t;

    localparam int BMEM_BEAT_W = 64;
    localparam int BMEM_BEATS  = 4;
    localparam int BMEM_LINE_W = 256;

endpackage

// File: rtl/bmem_burst_responder_line_ram.sv
// bmem_line_ram: line-granular backing store (MEM_LINES x 256 bits) with a
// per-beat write enable and a combinational whole-line read port. Not reset.
module bmem_line_ram
    import cache_types::*;
#(
    parameter int MEM_LINES = 256,
    localparam int IDX_W    = $clog2(MEM_LINES)
) (
    input  logic                   clk,
    input  logic [IDX_W-1:0]       idx,
    input  logic [BMEM_BEATS-1:0]  beat_we,
    input  logic [BMEM_BEAT_W-1:0] wdata,
    output logic [BMEM_LINE_W-1:0] rline
);

    logic [BMEM_LINE_W-1:0] mem [MEM_LINES];

    // Commit the write beat into every enabled 64-bit lane of the addressed line
    always_ff @(posedge clk) begin
        for (int b = 0; b < BMEM_BEATS; b++) begin
            if (beat_we[b]) begin
                mem[idx][b*BMEM_BEAT_W +: BMEM_BEAT_W] <= wdata;
            end
        end
    end

    assign rline = mem[idx];

endmodule

// File: rtl/bmem_burst_responder.sv
// bmem burst responder: accepts 4-beat write bursts and single-cycle read
// requests, returns lines as 4 back-to-back beats after READ_LATENCY cycles.
// Optional: define BMEM_RESP_STALL_EN to make bmem_ready alternate 0,1,...
// during write bursts (throttled writer path).
module bmem_burst_responder
    import cache_types::*;
#(
    parameter int MEM_LINES    = 256,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            bmem_addr,
    input  logic                   bmem_read,
    input  logic                   bmem_write,
    input  logic [BMEM_BEAT_W-1:0] bmem_wdata,
    output logic                   bmem_ready,
    output logic [31:0]            bmem_raddr,
    output logic [BMEM_BEAT_W-1:0] bmem_rdata,
    output logic                   bmem_rvalid
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

    bmem_resp_state_t       state, next_state;
    logic [1:0]             beat_cnt, beat_nxt;
    logic [LAT_W-1:0]       lat_cnt, lat_nxt;
    logic [31:5]            addr_q;
    logic                   addr_ld;
    logic [31:0]            line_addr;
    logic [BMEM_BEATS-1:0]  beat_we;
    logic [BMEM_LINE_W-1:0] ram_line;
    logic                   ready_nxt;
    logic                   rvalid_nxt;
    logic [BMEM_BEAT_W-1:0] rdata_nxt;
    logic                   addr_offset_unused;

    // Byte offset within a line carries no meaning for a line-granular store
    assign addr_offset_unused = ^bmem_addr[4:0];

    // In IDLE the request address goes straight to the store; otherwise the latched line
    assign line_addr = (state == IDLE) ? {bmem_addr[31:5], 5'b0} : {addr_q, 5'b0};

    bmem_line_ram #(
        .MEM_LINES(MEM_LINES)
    ) u_line_ram (
        .clk    (clk),
        .idx    (line_addr[5 +: IDX_W]),
        .beat_we(beat_we),
        .wdata  (bmem_wdata),
        .rline  (ram_line)
    );

    // Next-state, counters, write enables and address latch
    always_comb begin
        next_state = state;
        beat_nxt   = beat_cnt;
        lat_nxt    = lat_cnt;
        addr_ld    = 1'b0;
        beat_we    = '0;
        case (state)
            IDLE: begin
                if (bmem_ready && bmem_write) begin
                    beat_we    = 4'b0001;
                    addr_ld    = 1'b1;
                    beat_nxt   = 2'd1;
                    next_state = WR_BURST;
                end else if (bmem_ready && bmem_read) begin
                    addr_ld  = 1'b1;
                    lat_nxt  = LAT_LOAD;
                    beat_nxt = 2'd0;
                    // A single-cycle latency leaves no room for a wait state
                    next_state = (READ_LATENCY == 1) ? RD_BURST : RD_LAT;
                end
            end
            WR_BURST: begin
                if (bmem_ready && bmem_write) begin
                    beat_we  = 4'b0001 << beat_cnt;
                    beat_nxt = beat_cnt + 2'd1;
                    if (beat_cnt == 2'd3) begin
                        next_state = IDLE;
                    end
                end
            end
            RD_LAT: begin
                // Leave one cycle early: the registered outputs add the last cycle
                lat_nxt = lat_cnt - LAT_W'(1);
                if (lat_cnt <= LAT_W'(1)) begin
                    lat_nxt    = '0;
                    beat_nxt   = 2'd0;
                    next_state = RD_BURST;
                end
            end
            RD_BURST: begin
                beat_nxt = beat_cnt + 2'd1;
                if (beat_cnt == 2'd3) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                beat_nxt   = 2'd0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is heading
    always_comb begin
        ready_nxt = 1'b0;
        if (next_state == IDLE) begin
            ready_nxt = 1'b1;
        end else if (next_state == WR_BURST) begin
`ifdef BMEM_RESP_STALL_EN
            ready_nxt = (state == WR_BURST) ? ~bmem_ready : 1'b0;
`else
            ready_nxt = 1'b1;
`endif
        end
        rvalid_nxt = (next_state == RD_BURST);
        rdata_nxt  = rvalid_nxt ? ram_line[{beat_nxt, 6'd0} +: BMEM_BEAT_W] : '0;
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat_cnt    <= 2'd0;
            lat_cnt     <= '0;
            bmem_ready  <= 1'b0;
            bmem_rvalid <= 1'b0;
            bmem_rdata  <= '0;
            bmem_raddr  <= '0;
        end else begin
            state       <= next_state;
            beat_cnt    <= beat_nxt;
            lat_cnt     <= lat_nxt;
            bmem_ready  <= ready_nxt;
            bmem_rvalid <= rvalid_nxt;
            bmem_rdata  <= rdata_nxt;
            if (rvalid_nxt) begin
                bmem_raddr <= line_addr;
            end
        end
    end

    // Line address of the accepted request
    always_ff @(posedge clk) begin
        if (addr_ld) begin
            addr_q <= bmem_addr[31:5];
        end
    end

endmodule

// File: doc/bmem_burst_responder.md
Name: bmem_burst_responder

Overview:
- Memory-side responder for the bmem burst interface that the L2 cache-line adapter drives.
- Accepts 4-beat x 64-bit write bursts and single-cycle read requests.
- Returns 256-bit lines as 4 back-to-back 64-bit beats after a fixed latency.
- Holds a line-granular backing store; used as the synthesizable memory model under the L2 adapter and as the reference target for its verification.

Parameters:
- MEM_LINES, 256: number of 256-bit lines in the backing store; power of two.
- READ_LATENCY, 4: cycles from the accepted read request to the first rvalid beat; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- bmem_addr  in  32  request byte address; bits [4:0] ignored; line index = addr[5 +: log2(MEM_LINES)]
- bmem_read  in  1  read request
- bmem_write  in  1  write beat valid
- bmem_wdata  in  64  write beat data
- bmem_ready  out  1  a write beat or request presented this cycle is accepted
- bmem_raddr  out  32  line-aligned address of the returning burst
- bmem_rdata  out  64  read beat data
- bmem_rvalid  out  1  read beat valid

Behaviour:
- States: IDLE, WR_BURST, RD_LAT, RD_BURST. Counters: beat_cnt (2 bits), lat_cnt (sized to READ_LATENCY).
- Reset (rst low, asynchronous):
  - state = IDLE, beat_cnt = 0, lat_cnt = 0.
  - bmem_ready, bmem_rvalid = 0; bmem_raddr, bmem_rdata = 0.
  - Backing store is not cleared.
  - Reset mid-burst aborts the burst. Beats already written stay committed; the rest of the line is unchanged.
- IDLE:
  - bmem_ready = 1.
  - If bmem_write: beat 0 (wdata -> line[63:0]) is committed at this edge, the address is latched, beat_cnt = 1, go to WR_BURST.
  - Else if bmem_read: latch the line-aligned address, lat_cnt = READ_LATENCY-1, go to RD_LAT.
  - Write has priority when read and write are both high.
- WR_BURST:
  - bmem_ready = 1.
  - Each cycle with bmem_write & bmem_ready commits wdata -> line[64*beat_cnt +: 64] at the latched address; bmem_addr is ignored here.
  - Cycles without bmem_write hold beat_cnt.
  - After beat 3: beat_cnt = 0, go to IDLE.
  - Write latency with no stall: beat 0 at cycle T, beats 1-3 at T+1..T+3, IDLE at T+4.
- RD_LAT:
  - bmem_ready = 0.
  - lat_cnt decrements each cycle; at 0, go to RD_BURST with beat_cnt = 0.
  - bmem_read / bmem_write are ignored.
- RD_BURST:
  - bmem_rvalid = 1 for exactly 4 consecutive cycles, with no gaps; the initiator samples every cycle after the first rvalid.
  - bmem_rdata = line[64*beat_cnt +: 64]; bmem_raddr = latched line address, held for all 4 beats.
  - After beat 3: go to IDLE.
  - Read latency: request accepted at cycle T, beats at T+L..T+L+3 (L = READ_LATENCY), IDLE at T+L+4.
- Outputs are registered. bmem_rdata is 0 when rvalid is low.
- Read data reflects all write beats committed before the read request cycle.
- Requests outside IDLE are dropped. Address bits above the index field alias onto lower lines.

Optional Feature:
- Macro: BMEM_RESP_STALL_EN.
- When defined: in WR_BURST, bmem_ready alternates 0,1,0,1… starting at 0 on WR_BURST entry. A beat is accepted only when bmem_ready is high. A full write burst takes T..T+6, with IDLE at T+7.
- Read timing and IDLE acceptance are unchanged.
- When undefined: bmem_ready is constant 1 in WR_BURST.

Decomposition:
- cache_types gains:
  - bmem_resp_state_t (IDLE/WR_BURST/RD_LAT/RD_BURST)
  - BMEM_BEAT_W = 64
  - BMEM_BEATS = 4
  - BMEM_LINE_W = 256
- One sub-module, bmem_line_ram: MEM_LINES x 256 storage with a 4-bit per-beat write enable and a combinational line read port.

Test Plan:
- Write then read:
  - Stimulus: write burst to 0x0000_0040 with beats 0x1111…1, 0x2222…2, 0x3333…3, 0x4444…4; then a read of 0x0000_0040.
  - Required response: bmem_ready high on all 4 write cycles; rvalid exactly at T+4..T+7; rdata in beat order; raddr = 0x0000_0040.
- Unaligned address: read at 0x0000_005C -> raddr = 0x0000_0040, same data as the line above.
- Simultaneous read+write in IDLE: 0xAAAA… write burst -> write accepted, no rvalid; a later read returns 0xAAAA….
- Reset mid-burst:
  - Stimulus: write beats 0-1 of 0xBBBB… to line 3, drop rst for 1 cycle, then read line 3.
  - Required response: outputs 0 asynchronously during reset; read returns beats 0-1 new, beats 2-3 as previously stored.
- Request while busy: bmem_read pulsed during RD_LAT -> ignored; exactly one 4-beat burst is returned.
- With BMEM_RESP_STALL_EN: bmem_ready pattern in WR_BURST is 0,1,0,1,0,1; all 4 beats committed; IDLE at T+7.
